memory_access_unit: RTL and testbench
=====================================

# memory_access_unit

Sequences single-word read and write transactions between the processor datapath and a synchronous memory with variable latency. The block sits directly downstream of the memory address register. It takes the held address from `MAR_out` and write data from the data path, then drives the memory-side enable, write-enable, address and write-data lines. It waits a programmable number of cycles plus an optional `ready` extension, captures read data into a holding register, and reports completion to the control unit with a one-cycle `done` pulse.

## Interface
- `WAIT_STATES`, default 2: fixed extra cycles per access (0–15).
- `TIMEOUT`, default 15: maximum cycles to wait for `MAU_mem_ready` after the wait states expire (1–255).
- `MAU_clk`  in  1  system clock; all state changes on the rising edge.
- `MAU_rst`  in  1  reset, asynchronous, active-low.
- `MAU_addr_in`  in  16  access address, connected to `MAR_out`.
- `MAU_data_in`  in  16  write data.
- `MAU_rd_req`  in  1  read request, sampled in IDLE.
- `MAU_wr_req`  in  1  write request, sampled in IDLE.
- `MAU_busy`  out  1  transaction in progress.
- `MAU_done`  out  1  one-cycle completion pulse.
- `MAU_err`  out  1  one-cycle error pulse, coincident with `MAU_done` or alone (see below).
- `MAU_data_out`  out  16  last successfully read word.
- `MAU_mem_en`  out  1  memory enable.
- `MAU_mem_we`  out  1  memory write enable.
- `MAU_mem_addr`  out  16  memory address.
- `MAU_mem_wdata`  out  16  memory write data.
- `MAU_mem_rdata`  in  16  memory read data.
- `MAU_mem_ready`  in  1  memory ready; tie high for fixed-latency memory.

## Operation
- States: IDLE, ACCESS, DONE. All outputs are registered.
- **Reset** (`MAU_rst` low, any time, including mid-transaction):
  - State goes to IDLE.
  - Every output goes to 0, including `MAU_data_out` = 16'h0000.
  - Counters are cleared.
- **IDLE**
  - `MAU_busy`=0, `MAU_mem_en`=0, `MAU_mem_we`=0.
  - Exactly one of rd_req/wr_req high at an edge: latch `MAU_addr_in` into `MAU_mem_addr` and `MAU_data_in` into `MAU_mem_wdata`; set `MAU_mem_en`=1, `MAU_mem_we`=wr_req, `MAU_busy`=1; load wait counter with `WAIT_STATES` and timeout counter with `TIMEOUT`; go to ACCESS.
  - Both requests high: no access. Pulse `MAU_err` for one cycle without `MAU_done`, and stay in IDLE.
  - Neither request high: stay in IDLE.
- **ACCESS**
  - `MAU_mem_en`, `MAU_mem_we`, `MAU_mem_addr` and `MAU_mem_wdata` are held stable throughout.
  - Wait counter ≠ 0: decrement it.
  - Wait counter = 0 and `MAU_mem_ready`=1:
    - Read: capture `MAU_mem_rdata` into `MAU_data_out`.
    - Either operation: clear `MAU_mem_en`/`MAU_mem_we`, set `MAU_done`=1, go to DONE.
  - Wait counter = 0 and ready=0: decrement the timeout counter. When it reaches 0:
    - Clear `MAU_mem_en`/`MAU_mem_we`.
    - Set `MAU_done`=1 and `MAU_err`=1.
    - `MAU_data_out` is unchanged.
    - Go to DONE.
  - Requests arriving in ACCESS are ignored; they are not queued.
- **DONE**: lasts one cycle with `MAU_done` high and `MAU_busy`=1. On the next edge: `MAU_done`=0, `MAU_err`=0, `MAU_busy`=0, go to IDLE. Requests present during DONE are ignored.
- `MAU_data_out` changes only on a successful read.
- `MAU_mem_addr` and `MAU_mem_wdata` keep their last values in IDLE.

## Timing
- Request sampled at edge N:
  - `MAU_mem_en`/`MAU_busy` high after edge N.
  - With ready held high, `MAU_done` is high in the cycle after edge N+1+`WAIT_STATES`.
  - Total occupancy is `WAIT_STATES`+2 cycles in ACCESS/DONE.
  - The earliest next accept is edge N+`WAIT_STATES`+3.
- `WAIT_STATES`=0 with ready=1: `MAU_mem_en` is high for exactly 1 cycle, and `MAU_done` follows 1 cycle later.
- Each cycle of low ready after the wait states adds 1 cycle, up to `TIMEOUT` cycles.
- Read data is sampled on the same edge that sets `MAU_done`, and is valid in `MAU_data_out` while `MAU_done`=1.
- Reset assertion takes effect immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Test plan
- **Reset mid-access**: start a read, then pull `MAU_rst` low in ACCESS → all outputs are 0 immediately. After release, a new request succeeds normally.
- **Write, `WAIT_STATES`=2, ready=1**: `wr_req` with addr 16'h0040 and data 16'hBEEF at edge 0 → `mem_en`=`mem_we`=1 after edges 0–2 with addr/wdata stable; `done` high for 1 cycle after edge 3; `busy` low after edge 4; `data_out` unchanged.
- **Read, ready stretched**: read addr 16'h1234, memory returns 16'hA5A5, ready held low for 3 extra cycles → `done` is delayed by exactly 3 cycles and `data_out`=16'hA5A5 in the done cycle.
- **Timeout**: `TIMEOUT`=4, ready stuck at 0 → `done`=`err`=1 together after 2+4 ACCESS cycles (`WAIT_STATES`=2); `data_out` keeps its previous value.
- **Illegal and overlapping requests**: rd_req and wr_req both high in IDLE → one-cycle `err`, no `done`, `mem_en` stays 0. A second `rd_req` during ACCESS is ignored, and only one `done` is produced.

Source files
------------

// File: rtl/memory_access_unit.sv
// Sequences single-word reads and writes to a variable-latency synchronous memory.
// Every output is a flop. Completion is a one-cycle done pulse. A ready timeout is reported through err.
module memory_access_unit #(
  parameter int WAIT_STATES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic        MAU_clk,
  input  logic        MAU_rst,
  input  logic [15:0] MAU_addr_in,
  input  logic [15:0] MAU_data_in,
  input  logic        MAU_rd_req,
  input  logic        MAU_wr_req,
  output logic        MAU_busy,
  output logic        MAU_done,
  output logic        MAU_err,
  output logic [15:0] MAU_data_out,
  output logic        MAU_mem_en,
  output logic        MAU_mem_we,
  output logic [15:0] MAU_mem_addr,
  output logic [15:0] MAU_mem_wdata,
  input  logic [15:0] MAU_mem_rdata,
  input  logic        MAU_mem_ready
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [7:0] TMO_INIT  = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        en_q, en_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] dout_q, dout_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    en_d    = en_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        en_d   = 1'b0;
        we_d   = 1'b0;
        if (MAU_rd_req && MAU_wr_req) begin
          err_d = 1'b1;
        end else if (MAU_rd_req || MAU_wr_req) begin
          addr_d  = MAU_addr_in;
          wdata_d = MAU_data_in;
          en_d    = 1'b1;
          we_d    = MAU_wr_req;
          busy_d  = 1'b1;
          wait_d  = WAIT_INIT;
          tmo_d   = TMO_INIT;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else if (MAU_mem_ready) begin
          if (!we_q) begin
            dout_d = MAU_mem_rdata;
          end
          en_d    = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          // The timeout fires on the low-ready cycle that takes the counter to zero
          tmo_d = tmo_q - 8'd1;
          if (tmo_q <= 8'd1) begin
            tmo_d   = 8'd0;
            en_d    = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        en_d    = 1'b0;
        we_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge MAU_clk or negedge MAU_rst) begin
    if (!MAU_rst) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
      tmo_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      dout_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
    end
  end

  assign MAU_busy      = busy_q;
  assign MAU_done      = done_q;
  assign MAU_err       = err_q;
  assign MAU_data_out  = dout_q;
  assign MAU_mem_en    = en_q;
  assign MAU_mem_we    = we_q;
  assign MAU_mem_addr  = addr_q;
  assign MAU_mem_wdata = wdata_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit.
// A transaction-level model predicts the done cycle, err, and data_out from the wait-state and ready-stretch rules.
module tb_memory_access_unit;

  localparam int WS  = 2;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [15:0] addrIn = '0;
  logic [15:0] dataIn = '0;
  logic        rdReq = 1'b0;
  logic        wrReq = 1'b0;
  logic        busy, done, err, memEn, memWe;
  logic [15:0] dataOut, memAddr, memWdata;
  logic [15:0] memRdata = '0;
  logic        memReady = 1'b1;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] modelData = '0;
  logic [15:0] lastAddr = '0;
  logic [15:0] lastWdata = '0;

  memory_access_unit #(.WAIT_STATES(WS), .TIMEOUT(TMO)) dut (
    .MAU_clk       (clk),
    .MAU_rst       (rstN),
    .MAU_addr_in   (addrIn),
    .MAU_data_in   (dataIn),
    .MAU_rd_req    (rdReq),
    .MAU_wr_req    (wrReq),
    .MAU_busy      (busy),
    .MAU_done      (done),
    .MAU_err       (err),
    .MAU_data_out  (dataOut),
    .MAU_mem_en    (memEn),
    .MAU_mem_we    (memWe),
    .MAU_mem_addr  (memAddr),
    .MAU_mem_wdata (memWdata),
    .MAU_mem_rdata (memRdata),
    .MAU_mem_ready (memReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [4:0] ctl(input logic b, input logic e, input logic w, input logic d, input logic r);
    return {b, e, w, d, r};
  endfunction

  // One full transaction starting at a negedge.
  // mode 0: no extra requests, mode 1: rd_req held throughout, mode 2: random request noise.
  task automatic applyStimulus(input bit isWrite, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] rdata, input int lowCycles, input int mode);
    int          lat;
    bit          expErr;
    logic [15:0] expData;
    expErr  = (lowCycles >= TMO);
    lat     = expErr ? (WS + TMO) : (WS + 1 + lowCycles);
    expData = (!isWrite && !expErr) ? rdata : modelData;
    for (int j = 0; j <= lat + 1; j++) begin
      if (j == 0) begin
        rdReq  = !isWrite;
        wrReq  = isWrite;
        addrIn = addr;
        dataIn = wdata;
      end else if (mode == 1) begin
        rdReq  = 1'b1;
        wrReq  = 1'b0;
        addrIn = 16'($urandom);
      end else if (mode == 2) begin
        rdReq  = 1'($urandom);
        wrReq  = 1'($urandom);
        addrIn = 16'($urandom);
        dataIn = 16'($urandom);
      end else begin
        rdReq = 1'b0;
        wrReq = 1'b0;
      end
      memReady = (j <= WS) ? 1'($urandom) : (j >= WS + 1 + lowCycles);
      memRdata = (j == lat) ? rdata : 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (j < lat) begin
        checkOutput("access_ctl", 64'(ctl(busy, memEn, memWe, done, err)), 64'(ctl(1'b1, 1'b1, isWrite, 1'b0, 1'b0)));
        checkOutput("access_bus", 64'({memAddr, memWdata}), 64'({addr, wdata}));
        checkOutput("access_dout", 64'(dataOut), 64'(modelData));
      end else if (j == lat) begin
        checkOutput("done_ctl", 64'(ctl(busy, memEn, memWe, done, err)), 64'(ctl(1'b1, 1'b0, 1'b0, 1'b1, expErr)));
        checkOutput("done_dout", 64'(dataOut), 64'(expData));
      end else begin
        checkOutput("post_ctl", 64'(ctl(busy, memEn, memWe, done, err)), 64'(0));
        checkOutput("post_bus", 64'({memAddr, memWdata}), 64'({addr, wdata}));
      end
    end
    rdReq     = 1'b0;
    wrReq     = 1'b0;
    modelData = expData;
    lastAddr  = addr;
    lastWdata = wdata;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      rdReq  = 1'b0;
      wrReq  = 1'b0;
      addrIn = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      checkOutput("idle_ctl", 64'(ctl(busy, memEn, memWe, done, err)), 64'(0));
      checkOutput("idle_hold", 64'({memAddr, memWdata, dataOut}), 64'({lastAddr, lastWdata, modelData}));
    end
  endtask

  initial begin
    @(negedge clk);
    checkOutput("reset_ctl", 64'(ctl(busy, memEn, memWe, done, err)), 64'(0));
    checkOutput("reset_bus", 64'({dataOut, memAddr, memWdata}), 64'(0));
    rstN = 1'b1;
    idleCycles(1);

    applyStimulus(1'b1, 16'h0040, 16'hBEEF, 16'h0000, 0, 0);
    applyStimulus(1'b0, 16'h1234, 16'h0000, 16'hA5A5, 3, 0);
    applyStimulus(1'b0, 16'h2222, 16'h0000, 16'h5A5A, 4, 0);
    applyStimulus(1'b0, 16'h3333, 16'h0000, 16'h7777, 6, 0);

    rdReq  = 1'b1;
    wrReq  = 1'b1;
    addrIn = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    checkOutput("illegal_ctl", 64'(ctl(busy, memEn, memWe, done, err)), 64'(ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
    checkOutput("illegal_bus", 64'({memAddr, memWdata}), 64'({lastAddr, lastWdata}));
    idleCycles(1);

    applyStimulus(1'b0, 16'h4444, 16'h0000, 16'hC3C3, 1, 1);
    idleCycles(1);

    rdReq  = 1'b1;
    addrIn = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    rdReq = 1'b0;
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midreset_ctl", 64'(ctl(busy, memEn, memWe, done, err)), 64'(0));
    checkOutput("midreset_bus", 64'({dataOut, memAddr, memWdata}), 64'(0));
    modelData = '0;
    lastAddr  = '0;
    lastWdata = '0;
    @(negedge clk);
    rstN = 1'b1;
    idleCycles(1);
    applyStimulus(1'b0, 16'h6666, 16'h0000, 16'h1357, 0, 0);

    for (int t = 0; t < 40; t++) begin
      applyStimulus(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 2)));
      idleCycles(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
